// File: rtl/twi_slave_logic_pkg.sv
// Shared TWI responder definitions: FSM state encoding, SDA drive levels and
// address-byte layout.
package twi_slave_logic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } state_t;

    localparam logic       SDA_ACK     = 1'b0;
    localparam logic       SDA_RELEASE = 1'b1;
    localparam int         RW_BIT      = 0;
    localparam logic [2:0] BIT_MSB     = 3'd7;

endpackage

// File: rtl/twi_slave_logic_if.sv
// Bus pins plus the local byte handshakes of the TWI responder.
interface twi_slave_logic_if;

    logic       scl;
    logic       sda;
    logic       sda_drive;
    logic       enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       start;
    logic       stop;
    logic       busy;

    modport slave (
        input  scl, sda, enable, tx_data,
        output sda_drive, rx_data, rx_valid, rx_first, tx_req, start, stop, busy
    );

    modport master (
        output scl, sda, enable, tx_data,
        input  sda_drive, rx_data, rx_valid, rx_first, tx_req, start, stop, busy
    );

endinterface

// File: rtl/twi_slave_logic_filter.sv
// Pad conditioning for one TWI line: 2-FF synchroniser, run-length glitch
// filter and edge detection on the filtered level.
module twi_slave_logic_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_LOAD = 4'(FILTER_LEN - 1);

    logic       sync_a;
    logic       sync_b;
    logic       level_d;
    logic [3:0] cnt;

    // cnt counts down the remaining disagreeing samples before the level flips
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= CNT_LOAD;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == 4'd0) begin
                level <= sync_b;
                cnt   <= CNT_LOAD;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/twi_slave_logic.sv
// TWI responder: answers one 7-bit address, streams written bytes out and
// fetches read bytes on request. Never stretches SCL.
//
// state       | meaning
// ST_IDLE     | not addressed, waiting for START
// ST_ADDR     | shifting in address + R/W
// ST_ADDR_ACK | driving ACK for our address
// ST_WR_DATA  | shifting in a written byte
// ST_WR_ACK   | driving ACK for a written byte
// ST_RD_DATA  | driving a read byte MSB first
// ST_RD_ACK   | released, sampling master ACK/NACK
module twi_slave_logic
    import twi_slave_logic_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input logic              plb_clk,
    input logic              plb_reset,
    twi_slave_logic_if.slave bus
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    twi_slave_logic_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(plb_clk), .rst(plb_reset), .raw(bus.scl),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    twi_slave_logic_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(plb_clk), .rst(plb_reset), .raw(bus.sda),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] rx_data, rx_data_nxt;
    logic       byte_done, byte_done_nxt;
    logic       rw, rw_nxt;
    logic       first, first_nxt;
    logic       mack, mack_nxt;
    logic       sda_drive, sda_nxt;
    logic       rx_valid, rx_valid_nxt;
    logic       rx_first, rx_first_nxt;
    logic       tx_req, tx_req_nxt;
    logic       start, start_nxt;
    logic       stop, stop_nxt;

    // SCL high in this and the previous cycle: a filtered level without a rise
    logic scl_hi, start_cond, stop_cond;
    assign scl_hi     = scl_level & ~scl_rise;
    assign start_cond = scl_hi & sda_fall;
    assign stop_cond  = scl_hi & sda_rise;

    always_ff @(posedge plb_clk) begin
        if (plb_reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= BIT_MSB;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            first     <= 1'b0;
            mack      <= 1'b0;
            sda_drive <= SDA_RELEASE;
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
            tx_req    <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            rx_data   <= rx_data_nxt;
            byte_done <= byte_done_nxt;
            rw        <= rw_nxt;
            first     <= first_nxt;
            mack      <= mack_nxt;
            sda_drive <= sda_nxt;
            rx_valid  <= rx_valid_nxt;
            rx_first  <= rx_first_nxt;
            tx_req    <= tx_req_nxt;
            start     <= start_nxt;
            stop      <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        rx_data_nxt   = rx_data;
        byte_done_nxt = byte_done;
        rw_nxt        = rw;
        first_nxt     = first;
        mack_nxt      = mack;
        sda_nxt       = sda_drive;
        rx_valid_nxt  = 1'b0;
        rx_first_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        start_nxt     = 1'b0;
        stop_nxt      = 1'b0;

        if (start_cond) begin
            state_nxt     = ST_ADDR;
            bit_cnt_nxt   = BIT_MSB;
            byte_done_nxt = 1'b0;
            sda_nxt       = SDA_RELEASE;
            start_nxt     = 1'b1;
        end else if (stop_cond) begin
            state_nxt = ST_IDLE;
            sda_nxt   = SDA_RELEASE;
            stop_nxt  = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt     = {shift[6:0], sda_level};
                        bit_cnt_nxt   = bit_cnt - 3'd1;
                        byte_done_nxt = (bit_cnt == 3'd0);
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        if (state == ST_WR_DATA) begin
                            rx_data_nxt  = shift;
                            rx_valid_nxt = 1'b1;
                            rx_first_nxt = first;
                            first_nxt    = 1'b0;
                            sda_nxt      = SDA_ACK;
                            state_nxt    = ST_WR_ACK;
                        end else if (bus.enable && shift[7:1] == SLAVE_ADDR) begin
                            rw_nxt    = shift[RW_BIT];
                            first_nxt = 1'b1;
                            sda_nxt   = SDA_ACK;
                            state_nxt = ST_ADDR_ACK;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw) begin
                        tx_req_nxt = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_nxt = BIT_MSB;
                        if (rw) begin
                            shift_nxt = bus.tx_data;
                            sda_nxt   = bus.tx_data[7];
                            state_nxt = ST_RD_DATA;
                        end else begin
                            sda_nxt   = SDA_RELEASE;
                            state_nxt = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt     = SDA_RELEASE;
                        bit_cnt_nxt = BIT_MSB;
                        state_nxt   = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt   = bit_cnt - 3'd1;
                        byte_done_nxt = (bit_cnt == 3'd0);
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            byte_done_nxt = 1'b0;
                            sda_nxt       = SDA_RELEASE;
                            state_nxt     = ST_RD_ACK;
                        end else begin
                            shift_nxt = {shift[6:0], 1'b0};
                            sda_nxt   = shift[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        mack_nxt   = (sda_level == SDA_ACK);
                        tx_req_nxt = (sda_level == SDA_ACK);
                    end else if (scl_fall) begin
                        if (mack) begin
                            shift_nxt   = bus.tx_data;
                            sda_nxt     = bus.tx_data[7];
                            bit_cnt_nxt = BIT_MSB;
                            state_nxt   = ST_RD_DATA;
                        end else begin
                            sda_nxt   = SDA_RELEASE;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_drive = sda_drive;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.rx_first  = rx_first;
    assign bus.tx_req    = tx_req;
    assign bus.start     = start;
    assign bus.stop      = stop;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_twi_slave_logic.sv
// Bench for twi_slave_logic: bit-level TWI master on a wired-AND SDA, host
// model for read bytes, table vectors, corner sequences and random traffic.
module tb_twi_slave_logic;

    localparam int H = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic en = 1'b1;
    logic [7:0] tx_byte = 8'h00;

    int n_checks = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_stop = 0;
    int n_txreq = 0;
    logic [7:0] rx_q[$];
    logic       rxf_q[$];
    logic [7:0] tx_q[$];

    twi_slave_logic_if bus();
    assign bus.scl     = scl_m;
    assign bus.sda     = sda_m & bus.sda_drive;
    assign bus.enable  = en;
    assign bus.tx_data = tx_byte;

    twi_slave_logic #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .plb_clk(clk), .plb_reset(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Local-side observer and read-data host
    always @(negedge clk) begin
        if (bus.start) n_start++;
        if (bus.stop) n_stop++;
        if (bus.rx_valid) begin
            rx_q.push_back(bus.rx_data);
            rxf_q.push_back(bus.rx_first);
        end
        if (bus.tx_req) begin
            n_txreq++;
            tx_byte = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
        end
    end

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic        en;
        int          nb;
        logic [31:0] data;
        logic        exp_ack;
        int          exp_rx;
        int          exp_txreq;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input logic glitch, output logic s);
        sda_m = b;
        if (glitch) begin
            wait_cyc(3);
            scl_m = 1'b1;
            wait_cyc(1);
            scl_m = 1'b0;
            wait_cyc(H/2 - 4);
        end else begin
            wait_cyc(H/2);
        end
        scl_m = 1'b1;
        wait_cyc(H/2);
        s = bus.sda;
        wait_cyc(H/2);
        scl_m = 1'b0;
        wait_cyc(H/2);
    endtask

    task automatic do_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            wait_cyc(H/2);
            scl_m = 1'b1;
            wait_cyc(H/2);
        end
        sda_m = 1'b0;
        wait_cyc(H);
        scl_m = 1'b0;
        wait_cyc(H/2);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        wait_cyc(H/2);
        scl_m = 1'b1;
        wait_cyc(H);
        sda_m = 1'b1;
        wait_cyc(H);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == gbit), s);
        clk_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clk_bit(~mack, 1'b0, s);
    endtask

    // Expected outcome from the protocol rules alone
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_ack   = v.en && (v.addr == 7'h50);
        r.exp_rx    = (r.exp_ack && !v.rw) ? v.nb : 0;
        r.exp_txreq = (r.exp_ack && v.rw) ? v.nb : 0;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int s0, p0, r0, q0;
        logic aack, k;
        logic [7:0] b, got;
        s0 = n_start; p0 = n_stop; r0 = rx_q.size(); q0 = n_txreq;
        en = v.en;
        tx_q.delete();
        if (v.rw) for (int i = 0; i < v.nb; i++) tx_q.push_back(v.data[31-8*i -: 8]);
        do_start();
        wr_byte({v.addr, v.rw}, -1, aack);
        check({tag, " addr_ack"}, 32'(aack), 32'(v.exp_ack));
        check({tag, " busy_addressed"}, 32'(bus.busy), 32'(v.exp_ack));
        if (aack) begin
            for (int i = 0; i < v.nb; i++) begin
                b = v.data[31-8*i -: 8];
                if (!v.rw) begin
                    wr_byte(b, -1, k);
                    check({tag, " data_ack"}, 32'(k), 32'(1));
                end else begin
                    rd_byte(i < v.nb - 1, got);
                    check({tag, " read_byte"}, 32'(got), 32'(b));
                end
            end
        end
        do_stop();
        check({tag, " rx_count"}, 32'(rx_q.size() - r0), 32'(v.exp_rx));
        for (int i = 0; i < v.exp_rx && r0 + i < rx_q.size(); i++) begin
            check({tag, " rx_data"}, 32'(rx_q[r0+i]), 32'(v.data[31-8*i -: 8]));
            check({tag, " rx_first"}, 32'(rxf_q[r0+i]), 32'(i == 0));
        end
        check({tag, " tx_req_count"}, 32'(n_txreq - q0), 32'(v.exp_txreq));
        check({tag, " start_count"}, 32'(n_start - s0), 32'(1));
        check({tag, " stop_count"}, 32'(n_stop - p0), 32'(1));
        check({tag, " busy_after_stop"}, 32'(bus.busy), 32'(0));
    endtask

    initial begin
        int s0, r0, q0;
        logic k;
        logic [7:0] got;
        vec_t v;

        tbl[0] = '{7'h50, 1'b0, 1'b1, 1, 32'hA500_0000, 1'b1, 1, 0};
        tbl[1] = '{7'h51, 1'b0, 1'b1, 1, 32'h5500_0000, 1'b0, 0, 0};
        tbl[2] = '{7'h50, 1'b1, 1'b1, 2, 32'h3CC3_0000, 1'b1, 0, 2};
        tbl[3] = '{7'h50, 1'b0, 1'b0, 1, 32'h0F00_0000, 1'b0, 0, 0};
        tbl[4] = '{7'h50, 1'b0, 1'b1, 3, 32'h1234_5600, 1'b1, 3, 0};
        tbl[5] = '{7'h50, 1'b1, 1'b1, 1, 32'hFF00_0000, 1'b1, 0, 1};
        tbl[6] = '{7'h28, 1'b1, 1'b1, 1, 32'h8100_0000, 1'b0, 0, 0};

        rst = 1'b1;
        wait_cyc(4);
        check("reset sda_drive", 32'(bus.sda_drive), 32'(1));
        check("reset rx_data", 32'(bus.rx_data), 32'(0));
        check("reset rx_valid", 32'(bus.rx_valid), 32'(0));
        check("reset tx_req", 32'(bus.tx_req), 32'(0));
        check("reset start", 32'(bus.start), 32'(0));
        check("reset stop", 32'(bus.stop), 32'(0));
        check("reset busy", 32'(bus.busy), 32'(0));
        rst = 1'b0;
        wait_cyc(H + 4);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Write, repeated START, read
        en = 1'b1;
        s0 = n_start; r0 = rx_q.size(); q0 = n_txreq;
        tx_q.delete();
        tx_q.push_back(8'h77);
        do_start();
        wr_byte(8'hA0, -1, k);
        check("rs addr_w_ack", 32'(k), 32'(1));
        wr_byte(8'h11, -1, k);
        check("rs data_ack", 32'(k), 32'(1));
        do_start();
        wr_byte(8'hA1, -1, k);
        check("rs addr_r_ack", 32'(k), 32'(1));
        rd_byte(1'b0, got);
        check("rs read_byte", 32'(got), 32'h77);
        do_stop();
        check("rs rx_count", 32'(rx_q.size() - r0), 32'(1));
        if (rx_q.size() > r0) begin
            check("rs rx_data", 32'(rx_q[r0]), 32'h11);
            check("rs rx_first", 32'(rxf_q[r0]), 32'(1));
        end
        check("rs start_count", 32'(n_start - s0), 32'(2));
        check("rs tx_req_count", 32'(n_txreq - q0), 32'(1));

        // 1-cycle SCL glitch while SCL is low in the middle of a byte
        r0 = rx_q.size();
        do_start();
        wr_byte(8'hA0, -1, k);
        check("gl addr_ack", 32'(k), 32'(1));
        wr_byte(8'h96, 3, k);
        check("gl data_ack", 32'(k), 32'(1));
        do_stop();
        check("gl rx_count", 32'(rx_q.size() - r0), 32'(1));
        if (rx_q.size() > r0) check("gl rx_data", 32'(rx_q[r0]), 32'h96);

        // Reset while the slave holds the address ACK low
        r0 = rx_q.size();
        do_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] ab;
            ab = 8'hA0;
            clk_bit(ab[i], 1'b0, k);
        end
        sda_m = 1'b1;
        wait_cyc(H/2);
        scl_m = 1'b1;
        wait_cyc(H/2);
        check("rst ack_driven", 32'(bus.sda_drive), 32'(0));
        rst = 1'b1;
        wait_cyc(1);
        check("rst sda_released", 32'(bus.sda_drive), 32'(1));
        check("rst busy", 32'(bus.busy), 32'(0));
        rst = 1'b0;
        wait_cyc(H/2 - 1);
        scl_m = 1'b0;
        wait_cyc(H/2);
        wr_byte(8'h5A, -1, k);
        check("rst no_data_ack", 32'(k), 32'(0));
        check("rst busy_idle", 32'(bus.busy), 32'(0));
        do_stop();
        check("rst rx_count", 32'(rx_q.size() - r0), 32'(0));

        // Random traffic against the rule model
        for (int t = 0; t < 12; t++) begin
            v.addr = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
            v.rw   = 1'($urandom_range(0, 1));
            v.en   = ($urandom_range(0, 3) != 0);
            v.nb   = int'($urandom_range(1, 3));
            v.data = $urandom;
            v.exp_ack = 1'b0; v.exp_rx = 0; v.exp_txreq = 0;
            v = model(v);
            run_vec(v, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
